// File: rtl/prm_obs_scan_ctrl.sv
// prm_obs_scan_ctrl: feeds obstacle voxel codes one at a time to the shared
// per-edge checker bank and ORs the returned edge masks into a per-frame
// blocked-edge mask for the PRM planner.
// Optional feature: define PRM_OBS_CNT_EN to add the saturating obs_count output.
module prm_obs_scan_ctrl #(
  parameter int EDGE_NUM = 16,
  parameter int CODE_W   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                obs_valid,
  input  logic [CODE_W-1:0]   obs_code,
  input  logic                obs_last,
  output logic                obs_ready,
  output logic [CODE_W-1:0]   chk_code,
  input  logic [EDGE_NUM-1:0] chk_mask,
  output logic [EDGE_NUM-1:0] blocked_mask,
  output logic                busy,
  output logic                done
`ifdef PRM_OBS_CNT_EN
  ,
  output logic [15:0]         obs_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   chk_code_q, chk_code_d;
  logic                last_q, last_d;
  logic [EDGE_NUM-1:0] mask_q, mask_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic accept_start;
  logic handshake;
  logic kill;

  // Qualified events: abort beats start in IDLE and discards a coincident code in LOAD.
  always_comb begin
    accept_start = (state_q == S_IDLE) && start && !abort;
    handshake    = (state_q == S_LOAD) && obs_valid && !abort;
    kill         = abort && ((state_q == S_LOAD) || (state_q == S_CHECK));
  end

  // Next-state logic: two cycles per code, DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_start) state_d = S_LOAD;
      S_LOAD: begin
        if (abort)          state_d = S_IDLE;
        else if (obs_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (abort)       state_d = S_IDLE;
        else if (last_q) state_d = S_DONE;
        else             state_d = S_LOAD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture the code on handshake, fold the checker result in during CHECK.
  always_comb begin
    chk_code_d = chk_code_q;
    last_d     = last_q;
    mask_d     = mask_q;
    if (accept_start) mask_d = '0;
    if (handshake) begin
      chk_code_d = obs_code;
      last_d     = obs_last;
    end
    if ((state_q == S_CHECK) && !abort) mask_d = mask_q | chk_mask;
    if (kill) mask_d = '0;
  end

  // Output decode from the next state so the status outputs come straight from flops.
  always_comb begin
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      chk_code_q <= '0;
      last_q     <= 1'b0;
      mask_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      chk_code_q <= chk_code_d;
      last_q     <= last_d;
      mask_q     <= mask_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign obs_ready    = ready_q;
  assign chk_code     = chk_code_q;
  assign blocked_mask = mask_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef PRM_OBS_CNT_EN
  logic [15:0] count_q, count_d;

  // Saturating count of accepted codes; cleared by a new frame or an abort outside DONE.
  always_comb begin
    count_d = count_q;
    if (accept_start || (abort && (state_q != S_DONE))) count_d = '0;
    else if (handshake && (count_q != 16'hFFFF))        count_d = count_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign obs_count = count_q;
`endif

endmodule

// File: tb/tb_prm_obs_scan_ctrl.sv
// Testbench for prm_obs_scan_ctrl: directed frames from the test plan plus
// randomized frames with gaps, stray start pulses and aborts, checked against
// a frame-level reference (OR of checker results over the code list).
module tb_prm_obs_scan_ctrl;

  localparam int EDGE_NUM = 16;
  localparam int CODE_W   = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic                obs_valid;
  logic [CODE_W-1:0]   obs_code;
  logic                obs_last;
  logic                obs_ready;
  logic [CODE_W-1:0]   chk_code;
  logic [EDGE_NUM-1:0] chk_mask;
  logic [EDGE_NUM-1:0] blocked_mask;
  logic                busy;
  logic                done;
`ifdef PRM_OBS_CNT_EN
  logic [15:0]         obs_count;
`endif

  int vecCount = 0;
  int errCount = 0;

  logic [CODE_W-1:0] frameCodes[$];
  logic [CODE_W-1:0] expChk;

  always #5 clk = ~clk;

  prm_obs_scan_ctrl #(.EDGE_NUM(EDGE_NUM), .CODE_W(CODE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .obs_valid    (obs_valid),
    .obs_code     (obs_code),
    .obs_last     (obs_last),
    .obs_ready    (obs_ready),
    .chk_code     (chk_code),
    .chk_mask     (chk_mask),
    .blocked_mask (blocked_mask),
    .busy         (busy),
    .done         (done)
`ifdef PRM_OBS_CNT_EN
    ,
    .obs_count    (obs_count)
`endif
  );

  // Stand-in for the external checker bank: fixed answers for the plan's codes,
  // otherwise up to two blocked edges chosen by code nibbles.
  function automatic logic [EDGE_NUM-1:0] checkerModel(input logic [CODE_W-1:0] code);
    case (code)
      15'h0001: return 16'h0001;
      15'h2A55: return 16'h0100;
      15'h4003: return 16'h8000;
      default:  return (16'h0001 << code[3:0]) | (16'h0001 << code[11:8]);
    endcase
  endfunction

  assign chk_mask = checkerModel(chk_code);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from frameCodes with random gaps; checks every cycle.
  task automatic applyStimulus(input int maxGap, input bit randStart, output logic [EDGE_NUM-1:0] finalMask);
    logic [EDGE_NUM-1:0] expMask;
    int n;
    int gap;
    expMask = '0;
    n = frameCodes.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_ready", obs_ready, 1);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_mask", blocked_mask, 0);
`ifdef PRM_OBS_CNT_EN
    checkOutput("start_count", obs_count, 0);
`endif
    for (int i = 0; i < n; i++) begin
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        obs_valid = 1'b0;
        obs_code  = CODE_W'($urandom);
        start     = randStart ? 1'($urandom) : 1'b0;
        tick();
        checkOutput("gap_ready", obs_ready, 1);
        checkOutput("gap_code", chk_code, expChk);
        checkOutput("gap_mask", blocked_mask, expMask);
        checkOutput("gap_done", done, 0);
      end
      start     = 1'b0;
      obs_valid = 1'b1;
      obs_code  = frameCodes[i];
      obs_last  = (i == n - 1);
      tick();
      obs_valid = 1'b0;
      obs_last  = 1'b0;
      obs_code  = CODE_W'($urandom);
      expChk    = frameCodes[i];
      checkOutput("check_ready", obs_ready, 0);
      checkOutput("check_code", chk_code, expChk);
      checkOutput("check_mask", blocked_mask, expMask);
      checkOutput("check_done", done, 0);
      tick();
      expMask = expMask | checkerModel(frameCodes[i]);
      checkOutput("acc_mask", blocked_mask, expMask);
      if (i < n - 1) begin
        checkOutput("reload_ready", obs_ready, 1);
        checkOutput("reload_done", done, 0);
      end
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 1);
    checkOutput("done_ready", obs_ready, 0);
`ifdef PRM_OBS_CNT_EN
    checkOutput("done_count", obs_count, n);
`endif
    abort = 1'($urandom);
    tick();
    abort = 1'b0;
    checkOutput("post_done", done, 0);
    checkOutput("post_busy", busy, 0);
    checkOutput("post_mask", blocked_mask, expMask);
    checkOutput("post_code", chk_code, expChk);
`ifdef PRM_OBS_CNT_EN
    checkOutput("post_count", obs_count, n);
`endif
    finalMask = expMask;
  endtask

  initial begin
    logic [EDGE_NUM-1:0] m;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    obs_valid = 1'b0; obs_code = '0; obs_last = 1'b0;
    expChk = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_ready", obs_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_mask", blocked_mask, 0);
    checkOutput("rst_code", chk_code, 0);
`ifdef PRM_OBS_CNT_EN
    checkOutput("rst_count", obs_count, 0);
`endif
    obs_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle_ready", obs_ready, 0);
      checkOutput("idle_busy", busy, 0);
    end
    obs_valid = 1'b0;

    // Three-code frame without gaps, then the same with gaps and stray starts.
    frameCodes = '{15'h0001, 15'h2A55, 15'h4003};
    applyStimulus(0, 1'b0, m);
    checkOutput("plan_mask", m, 16'h8101);
    applyStimulus(3, 1'b1, m);
    checkOutput("plan_gap_mask", m, 16'h8101);

    // Abort during the second code's CHECK cycle.
    start = 1'b1; tick(); start = 1'b0;
    obs_valid = 1'b1; obs_code = 15'h0123; obs_last = 1'b0; tick();
    obs_valid = 1'b0; tick();
    obs_valid = 1'b1; obs_code = 15'h0456; tick();
    obs_valid = 1'b0; expChk = 15'h0456;
    abort = 1'b1; tick(); abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_mask", blocked_mask, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_ready", obs_ready, 0);
    tick();
    checkOutput("abort_nodone", done, 0);

    // Abort coinciding with a LOAD handshake discards the code.
    start = 1'b1; tick(); start = 1'b0;
    obs_valid = 1'b1; obs_code = 15'h7777; obs_last = 1'b1; abort = 1'b1; tick();
    obs_valid = 1'b0; obs_last = 1'b0; abort = 1'b0;
    checkOutput("abort_hs_busy", busy, 0);
    checkOutput("abort_hs_code", chk_code, expChk);
`ifdef PRM_OBS_CNT_EN
    checkOutput("abort_hs_count", obs_count, 0);
`endif

    // Start and abort together in IDLE stay in IDLE.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    checkOutput("collide_busy", busy, 0);
    checkOutput("collide_ready", obs_ready, 0);
    tick();
    checkOutput("collide_busy2", busy, 0);

    // Clean frame after the aborts.
    frameCodes = '{15'h0001, 15'h2A55, 15'h4003, 15'h0F0F, 15'h1234};
    applyStimulus(1, 1'b0, m);
    checkOutput("clean_mask", m, 16'h8101 | 16'h8000 | 16'h0014);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      int n;
      n = int'($urandom_range(8, 1));
      frameCodes.delete();
      for (int i = 0; i < n; i++) frameCodes.push_back(CODE_W'($urandom));
      applyStimulus(3, 1'b1, m);
    end

    // Reset in the middle of a frame.
    start = 1'b1; tick(); start = 1'b0;
    obs_valid = 1'b1; obs_code = 15'h5A5A; obs_last = 1'b0; tick();
    obs_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    expChk = '0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", obs_ready, 0);
    checkOutput("midrst_code", chk_code, 0);
    checkOutput("midrst_mask", blocked_mask, 0);
    checkOutput("midrst_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
